// File: rtl/conv_enc_if.sv
// Handshake bundle for the rate-1/2 K=3 convolutional encoder: bit input side,
// symbol output side, completed-frame counter and FSM debug view.
interface conv_enc_if;
  logic        in_valid_i;
  logic        in_bit_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  sym_o;
  logic        out_first_o;
  logic        out_last_o;
  logic [15:0] frame_cnt_o;
  logic [1:0]  state_dbg;    // {in_tail, tail_idx}

  // Both sides use valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; valid and its payload stay stable until then.
  modport master (
    output in_valid_i, in_bit_i, out_ready_i,
    input  in_ready_o, out_valid_o, sym_o, out_first_o, out_last_o,
           frame_cnt_o, state_dbg
  );

  modport slave (
    input  in_valid_i, in_bit_i, out_ready_i,
    output in_ready_o, out_valid_o, sym_o, out_first_o, out_last_o,
           frame_cnt_o, state_dbg
  );
endinterface

// File: rtl/conv_enc_tx.sv
// Rate-1/2, K=3 (7,5 octal) convolutional encoder with one registered output slot
// and optional two-symbol zero tail per frame.
module conv_enc_tx #(
  parameter int FRAME_LEN = 16,
  parameter bit TAIL_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  conv_enc_if.slave  io
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic {ST_DATA = 1'b0, ST_TAIL = 1'b1} state_t;

  state_t          state;
  logic [1:0]      sr;
  logic [CW-1:0]   bit_cnt;
  logic            tail_idx;
  logic            out_valid;
  logic [1:0]      sym;
  logic            out_first;
  logic            out_last;
  logic [15:0]     frame_cnt;

  logic            slot_free;
  logic            in_ready;
  logic            accept;
  logic            last_bit;
  logic            enc_u;
  logic [1:0]      sym_next;

  assign slot_free = !out_valid || io.out_ready_i;
  assign in_ready  = !rst && (state == ST_DATA) && slot_free;
  assign accept    = io.in_valid_i && in_ready;
  assign last_bit  = (bit_cnt == CW'(FRAME_LEN - 1));

  // Tail symbols are the encoder driven with u = 0.
  assign enc_u    = (state == ST_DATA) ? io.in_bit_i : 1'b0;
  assign sym_next = {enc_u ^ sr[1] ^ sr[0], enc_u ^ sr[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_DATA;
      sr        <= 2'b00;
      bit_cnt   <= '0;
      tail_idx  <= 1'b0;
      out_valid <= 1'b0;
      sym       <= 2'b00;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      if (out_valid && io.out_ready_i && out_last)
        frame_cnt <= frame_cnt + 16'd1;

      // Nothing moves while the slot is held by a stalled symbol.
      if (slot_free) begin
        if (state == ST_DATA) begin
          if (accept) begin
            out_valid <= 1'b1;
            sym       <= sym_next;
            out_first <= (bit_cnt == '0);
            if (last_bit && !TAIL_EN) begin
              out_last <= 1'b1;
              sr       <= 2'b00;
              bit_cnt  <= '0;
            end else begin
              out_last <= 1'b0;
              sr       <= {enc_u, sr[1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (last_bit) begin
                state    <= ST_TAIL;
                tail_idx <= 1'b0;
              end
            end
          end else begin
            out_valid <= 1'b0;
          end
        end else begin
          out_valid <= 1'b1;
          sym       <= sym_next;
          out_first <= 1'b0;
          tail_idx  <= 1'b1;
          if (tail_idx) begin
            out_last <= 1'b1;
            sr       <= 2'b00;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            out_last <= 1'b0;
            sr       <= {1'b0, sr[1]};
          end
        end
      end
    end
  end

  assign io.in_ready_o  = in_ready;
  assign io.out_valid_o = out_valid;
  assign io.sym_o       = sym;
  assign io.out_first_o = out_first;
  assign io.out_last_o  = out_last;
  assign io.frame_cnt_o = frame_cnt;
  assign io.state_dbg   = {state == ST_TAIL, tail_idx};

endmodule

// File: tb/tb_conv_enc_tx.sv
// Directed bench for conv_enc_tx: three parameterisations (4/tail, 4/no tail,
// 1/no tail) share one stimulus/monitor process selected by sel.
module tb_conv_enc_tx;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_bit;
  logic rdy_lvl;
  logic tog_en;
  logic phase;
  logic out_ready;
  int   sel;

  conv_enc_if a_if();
  conv_enc_if b_if();
  conv_enc_if c_if();

  assign out_ready = tog_en ? phase : rdy_lvl;

  assign a_if.in_valid_i  = in_valid && (sel == 0);
  assign b_if.in_valid_i  = in_valid && (sel == 1);
  assign c_if.in_valid_i  = in_valid && (sel == 2);
  assign a_if.in_bit_i    = in_bit;
  assign b_if.in_bit_i    = in_bit;
  assign c_if.in_bit_i    = in_bit;
  assign a_if.out_ready_i = out_ready;
  assign b_if.out_ready_i = out_ready;
  assign c_if.out_ready_i = out_ready;

  conv_enc_tx #(.FRAME_LEN(4), .TAIL_EN(1'b1)) u_a (.clk(clk), .rst(rst), .io(a_if));
  conv_enc_tx #(.FRAME_LEN(4), .TAIL_EN(1'b0)) u_b (.clk(clk), .rst(rst), .io(b_if));
  conv_enc_tx #(.FRAME_LEN(1), .TAIL_EN(1'b0)) u_c (.clk(clk), .rst(rst), .io(c_if));

  // Observed view of the selected instance; word = {first, last, sym}.
  logic        obs_valid;
  logic        obs_in_ready;
  logic [3:0]  obs_word;
  logic [15:0] obs_fc;
  logic [1:0]  obs_dbg;

  always_comb begin
    obs_valid    = a_if.out_valid_o;
    obs_in_ready = a_if.in_ready_o;
    obs_word     = {a_if.out_first_o, a_if.out_last_o, a_if.sym_o};
    obs_fc       = a_if.frame_cnt_o;
    obs_dbg      = a_if.state_dbg;
    case (sel)
      1: begin
        obs_valid    = b_if.out_valid_o;
        obs_in_ready = b_if.in_ready_o;
        obs_word     = {b_if.out_first_o, b_if.out_last_o, b_if.sym_o};
        obs_fc       = b_if.frame_cnt_o;
        obs_dbg      = b_if.state_dbg;
      end
      2: begin
        obs_valid    = c_if.out_valid_o;
        obs_in_ready = c_if.in_ready_o;
        obs_word     = {c_if.out_first_o, c_if.out_last_o, c_if.sym_o};
        obs_fc       = c_if.frame_cnt_o;
        obs_dbg      = c_if.state_dbg;
      end
      default: ;
    endcase
  end

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state
  logic [3:0]  exp_q[$];
  logic [15:0] exp_fc;
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          hs_cnt;
  int          last_hs_cyc;
  int          ir_low;
  logic        ir_seen;
  logic        prev_stall;
  logic [3:0]  prev_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor work at the falling edge, then advance to just after the next rising edge.
  task automatic step();
    logic [3:0] e;
    @(negedge clk);
    check("fcnt", {16'd0, obs_fc}, {16'd0, exp_fc});
    if (prev_stall) begin
      check("hold_valid", {31'd0, obs_valid}, 32'd1);
      check("hold_word", {28'd0, obs_word}, {28'd0, prev_word});
    end
    if (rst) begin
      check("rst_ready", {31'd0, obs_in_ready}, 32'd0);
      exp_fc     = 16'd0;
      prev_stall = 1'b0;
    end else begin
      if (obs_valid && !out_ready)
        check("stall_ready", {31'd0, obs_in_ready}, 32'd0);
      if (obs_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_sym", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sym", {28'd0, obs_word}, {28'd0, e});
          if (obs_word[2]) exp_fc = exp_fc + 16'd1;
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      prev_stall = obs_valid && !out_ready;
      prev_word  = obs_word;
      if (!obs_in_ready) ir_low++;
    end
    ir_seen = obs_in_ready;
    @(posedge clk);
    cyc++;
    #1;
    if (tog_en) phase = ~phase;
  endtask

  task automatic send_bit(input logic b);
    int n;
    in_valid = 1'b1;
    in_bit   = b;
    n = 0;
    do begin
      step();
      n++;
    end while (!ir_seen && n < 100);
    if (!ir_seen) check("send_timeout", n, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || obs_valid) && n < 200) begin
      step();
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_frame4(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
  endtask

  // Frame 1,0,1,1 with tail: 11,10,00,01,01,11.
  task automatic push_frame_1011_tail();
    exp_q.push_back(4'b10_11);
    exp_q.push_back(4'b00_10);
    exp_q.push_back(4'b00_00);
    exp_q.push_back(4'b00_01);
    exp_q.push_back(4'b00_01);
    exp_q.push_back(4'b01_11);
  endtask

  int   t0;
  int   hs0;
  int   ir0;
  logic b;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
    rdy_lvl = 1'b1; tog_en = 1'b0; phase = 1'b0; sel = 0;
    exp_fc = 16'd0; n_checks = 0; n_errors = 0; cyc = 0;
    hs_cnt = 0; last_hs_cyc = 0; ir_low = 0; ir_seen = 1'b0;
    prev_stall = 1'b0; prev_word = 4'd0;

    do_reset();
    check("rst_valid", {31'd0, obs_valid}, 32'd0);
    check("rst_word", {28'd0, obs_word}, 32'd0);
    check("rst_fc", {16'd0, obs_fc}, 32'd0);
    check("rst_state", {30'd0, obs_dbg}, 32'd0);

    // Reset mid-frame: two bits drained, a third held in a stalled slot.
    exp_q.push_back(4'b10_11);
    exp_q.push_back(4'b00_10);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_drain();
    rdy_lvl = 1'b0;
    send_bit(1'b1);
    step();
    check("mid_pending", {31'd0, obs_valid}, 32'd1);
    do_reset();
    check("mid_rst_valid", {31'd0, obs_valid}, 32'd0);
    check("mid_rst_fc", {16'd0, obs_fc}, 32'd0);
    rdy_lvl = 1'b1;

    // Basic frame, full throughput.
    push_frame_1011_tail();
    hs0 = hs_cnt;
    t0  = cyc;
    send_frame4(4'b1011);
    wait_drain();
    check("basic_count", hs_cnt - hs0, 32'd6);
    check("basic_span", last_hs_cyc - t0, 32'd6);
    check("basic_fc", {16'd0, obs_fc}, 32'd1);

    // Same frame with out_ready toggling every cycle.
    tog_en = 1'b1;
    push_frame_1011_tail();
    hs0 = hs_cnt;
    send_frame4(4'b1011);
    wait_drain();
    tog_en = 1'b0;
    check("toggle_count", hs_cnt - hs0, 32'd6);
    check("toggle_fc", {16'd0, obs_fc}, 32'd2);

    // Three back-to-back tailed frames.
    do_reset();
    push_frame_1011_tail();
    exp_q.push_back(4'b10_11); exp_q.push_back(4'b00_01);
    exp_q.push_back(4'b00_10); exp_q.push_back(4'b00_10);
    exp_q.push_back(4'b00_01); exp_q.push_back(4'b01_11);
    exp_q.push_back(4'b10_11); exp_q.push_back(4'b00_10);
    exp_q.push_back(4'b00_11); exp_q.push_back(4'b00_00);
    exp_q.push_back(4'b00_00); exp_q.push_back(4'b01_00);
    hs0 = hs_cnt;
    ir0 = ir_low;
    t0  = cyc;
    send_frame4(4'b1011);
    send_frame4(4'b1111);
    send_frame4(4'b1000);
    wait_drain();
    check("b2b_count", hs_cnt - hs0, 32'd18);
    check("b2b_span", last_hs_cyc - t0, 32'd18);
    check("b2b_ready_low", ir_low - ir0, 32'd6);
    check("b2b_fc", {16'd0, obs_fc}, 32'd3);

    // No-tail frames: encoder state restarts at 00 for the second frame.
    do_reset();
    sel = 1;
    exp_q.push_back(4'b10_11); exp_q.push_back(4'b00_01);
    exp_q.push_back(4'b00_10); exp_q.push_back(4'b01_10);
    exp_q.push_back(4'b10_11); exp_q.push_back(4'b00_10);
    exp_q.push_back(4'b00_11); exp_q.push_back(4'b01_00);
    hs0 = hs_cnt;
    t0  = cyc;
    send_frame4(4'b1111);
    send_frame4(4'b1000);
    wait_drain();
    check("notail_count", hs_cnt - hs0, 32'd8);
    check("notail_span", last_hs_cyc - t0, 32'd8);
    check("notail_fc", {16'd0, obs_fc}, 32'd2);

    // Single-bit frames: counter reaches 0xFFFF, then wraps on the next frame.
    do_reset();
    sel = 2;
    for (int i = 0; i < 65535; i++) begin
      b = (i % 2 == 1) ^ ((i / 8) % 2 == 1);
      exp_q.push_back({2'b11, b, b});
      send_bit(b);
    end
    wait_drain();
    check("wrap_pre", {16'd0, obs_fc}, 32'h0000_FFFF);
    exp_q.push_back(4'b11_11);
    send_bit(1'b1);
    wait_drain();
    check("wrap_post", {16'd0, obs_fc}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_enc_tx.md
# conv_enc_tx

Rate-1/2, constraint-length-3 convolutional encoder (generators 7 and 5 octal) that produces the coded symbol stream consumed by the Viterbi decoder (BMU/ACSU/PMU/traceback chain). It accepts one information bit per handshake, emits one registered 2-bit symbol per handshake, and zero-terminates each frame with K-1 = 2 tail symbols so the decoder's trellis starts and ends in state S0. Used in the transmit path and as the golden stimulus source for the decoder bench.

## Interface
- FRAME_LEN, 16: information bits per frame; legal range 1..65535.
- TAIL_EN, 1: 1 = append 2 zero-input tail symbols per frame; 0 = no tail.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid_i  input  1  in_bit_i is valid.
- in_bit_i  input  1  information bit.
- in_ready_o  output  1  encoder accepts a bit this cycle.
- out_valid_o  output  1  sym_o holds a valid symbol.
- out_ready_i  input  1  downstream accepts sym_o this cycle.
- sym_o  output  2  coded symbol: [1] = g0 (111), [0] = g1 (101).
- out_first_o  output  1  sym_o is the first symbol of a frame.
- out_last_o  output  1  sym_o is the last symbol of a frame.
- frame_cnt_o  output  16  completed frames (last symbol handed off), wraps at 2^16.

## Operation
- Encoder state sr[1:0]: sr[1] = previous input bit, sr[0] = bit before that. Frame start value 2'b00.
- For input u: g0 = u ^ sr[1] ^ sr[0]; g1 = u ^ sr[0]; next sr = {u, sr[1]}.
- Output slot: one register (sym_o, out_first_o, out_last_o, out_valid_o). Slot is "free" when !out_valid_o || out_ready_i.
- bit_cnt: counts accepted bits in current frame, width $clog2(FRAME_LEN+1), 0 at frame start.
- FSM states:
  - DATA: in_ready_o = slot free. On accept (in_valid_i && in_ready_o): load slot with encoded symbol, update sr, bit_cnt++. out_first_o = (bit_cnt == 0). If this is bit FRAME_LEN: TAIL_EN=1 -> go TAIL (tail_idx = 0), out_last_o = 0; TAIL_EN=0 -> out_last_o = 1, sr <= 00, bit_cnt <= 0, stay DATA.
  - TAIL: in_ready_o = 0. When slot free: load slot with symbol for u = 0, update sr, tail_idx++. Second tail symbol sets out_last_o = 1, forces sr <= 00, bit_cnt <= 0, returns to DATA.
- When slot free and nothing loaded: out_valid_o <= 0.
- Backpressure: while out_valid_o && !out_ready_i, sym_o/flags/out_valid_o hold stable; no state, sr or counter change.
- frame_cnt_o increments in the cycle the out_last_o symbol is handed off (out_valid_o && out_ready_i && out_last_o); wraps 0xFFFF -> 0x0000.
- FRAME_LEN = 1: single symbol carries out_first_o; with TAIL_EN=0 it also carries out_last_o.

## Timing
- Reset (rst high at clk edge): FSM = DATA, sr = 00, bit_cnt = 0, tail_idx = 0, out_valid_o = 0, sym_o = 00, out_first_o = 0, out_last_o = 0, frame_cnt_o = 0. Reset mid-frame discards partial frame and pending symbol; next accepted bit starts a new frame. in_ready_o low during reset cycle.
- Latency: symbol for a bit accepted at edge N is on sym_o with out_valid_o = 1 after edge N (visible cycle N+1).
- Throughput: 1 symbol/cycle with out_ready_i held high, including pass-through (accept new bit in same cycle slot is drained).
- Frame with TAIL_EN=1 occupies FRAME_LEN+2 output symbols; in_ready_o low for exactly 2 cycles between frames when out_ready_i = 1.
- in_ready_o is combinational from out_valid_o, out_ready_i and FSM state only; never from in_valid_i.
- Simultaneous drain of last symbol and accept of next frame's first bit is legal; frame_cnt_o and new-frame out_first_o update on the same edge.

## Test plan
- FRAME_LEN=4, TAIL_EN=1, bits 1,0,1,1, out_ready_i=1 -> sym_o 11,10,00,01,01,11 on 6 consecutive cycles; first flag on 11, last flag on final 11; frame_cnt_o = 1.
- Same frame with out_ready_i toggling 1/0 each cycle -> identical symbol sequence, sym_o stable while stalled, no dropped/duplicated symbols, in_ready_o low during stalls with slot full.
- FRAME_LEN=4, TAIL_EN=0, bits 1,1,1,1 then 1,0,0,0 -> 11,01,10,10 then 11,10,11,00 (sr restarts at 00); last flag on 4th and 8th symbols.
- Back-to-back frames (FRAME_LEN=4, TAIL_EN=1) with continuous in_valid_i -> in_ready_o low exactly 2 cycles per frame, no bubbles on output, frame_cnt_o counts 1,2,3.
- rst asserted after 2 bits of a frame -> out_valid_o = 0, frame_cnt_o unchanged at 0, next frame 1,0,1,1 reproduces 11,10,00,01,01,11 with first flag on initial 11.
- frame_cnt_o preset via 65536 short frames (FRAME_LEN=1) -> wraps to 0 on the 65536th completed frame.
